mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that sits beside the unified memory on the multicycle core's data port. It consumes the same store traffic the memory sees (MemWrite, DataAdr, WriteData), buffers bytes stored to its TXDATA address in a small FIFO, and serialises them 8N1 on `tx`. It also returns a status word on the read path so software can poll for space and completion.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/mmio_uart_tx.sv | 180 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the memory-mapped UART transmitter.
// Build option UART_PARITY_EN adds the PARITY state to the frame.
package uart_pkg;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
`endif

    localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_FULL_BIT = 1;
    localparam int unsigned STATUS_OVF_BIT  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset; dout shows the head entry while not empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping the core's store port (TXDATA at +0, STATUS at +4).
// Defining UART_PARITY_EN inserts an even-parity bit between data and stop.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] RdData,
    output logic        Hit,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned   TW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

    uart_state_t   state;
    logic [TW-1:0] bit_timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          overflow;
`ifdef UART_PARITY_EN
    logic          parity;
`endif

    logic       txdata_sel;
    logic       status_sel;
    logic       bit_done;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       unused_wdata;

    assign unused_wdata = ^WriteData[31:8];

    assign txdata_sel = (DataAdr == BASE_ADDR + TXDATA_OFS);
    assign status_sel = (DataAdr == BASE_ADDR + STATUS_OFS);
    assign Hit        = (DataAdr[31:3] == BASE_ADDR[31:3]);
    assign fifo_push  = MemWrite && txdata_sel;
    assign bit_done   = (bit_timer == BIT_LAST);
    // Pop from IDLE, or on the last stop-bit cycle so frames run back to back.
    assign fifo_pop   = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));
    assign busy       = (state != IDLE) || !fifo_empty;

    always_comb begin
        RdData = '0;
        if (status_sel) begin
            RdData[STATUS_BUSY_BIT] = busy;
            RdData[STATUS_FULL_BIT] = fifo_full;
            RdData[STATUS_OVF_BIT]  = overflow;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (WriteData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Fullness is judged before the edge, so a simultaneous pop does not rescue the byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (fifo_push && fifo_full) begin
            overflow <= 1'b1;
        end else if (MemWrite && status_sel) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_timer <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            tx        <= 1'b1;
`ifdef UART_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    bit_timer <= '0;
                    tx        <= 1'b1;
                    if (fifo_pop) begin
                        state <= START;
                        shift <= fifo_dout;
                        tx    <= 1'b0;
`ifdef UART_PARITY_EN
                        parity <= ^fifo_dout;
`endif
                    end
                end
                START: begin
                    if (bit_done) begin
                        state     <= DATA;
                        bit_timer <= '0;
                        bit_idx   <= '0;
                        tx        <= shift[0];
                    end else begin
                        bit_timer <= bit_timer + TW'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_timer <= '0;
                        shift     <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            state <= PARITY;
                            tx    <= parity;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end else begin
                        bit_timer <= bit_timer + TW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state     <= STOP;
                        bit_timer <= '0;
                        tx        <= 1'b1;
                    end else begin
                        bit_timer <= bit_timer + TW'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        bit_timer <= '0;
                        if (fifo_pop) begin
                            state <= START;
                            shift <= fifo_dout;
                            tx    <= 1'b0;
`ifdef UART_PARITY_EN
                            parity <= ^fifo_dout;
`endif
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        bit_timer <= bit_timer + TW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    bit_timer <= '0;
                    tx        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a waveform-queue model checked every cycle plus literal spot checks.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          C     = 4;
    localparam int          DEPTH = 4;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        MemWrite  = 1'b0;
    logic [31:0] DataAdr   = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] RdData;
    logic        Hit;
    logic        tx;
    logic        busy;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // Model: pending bytes, and the tx level expected after each upcoming edge.
    logic [7:0] mq[$];
    logic       mwave[$];
    logic       movf = 1'b0;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .RdData    (RdData),
        .Hit       (Hit),
        .tx        (tx),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int         pre;
        logic [7:0] b;
        if (reset) begin
            mq.delete();
            mwave.delete();
            movf = 1'b0;
        end else begin
            pre = mq.size();
            if (mwave.size() > 0) void'(mwave.pop_front());
            if (mwave.size() == 0 && pre > 0) begin
                b = mq.pop_front();
                for (int k = 0; k < C; k++) mwave.push_back(1'b0);
                for (int i = 0; i < 8; i++)
                    for (int k = 0; k < C; k++) mwave.push_back(b[i]);
`ifdef UART_PARITY_EN
                for (int k = 0; k < C; k++) mwave.push_back(^b);
`endif
                for (int k = 0; k < C; k++) mwave.push_back(1'b1);
            end
            if (MemWrite && DataAdr == BASE) begin
                if (pre >= DEPTH) movf = 1'b1;
                else mq.push_back(WriteData[7:0]);
            end
            if (MemWrite && DataAdr == BASE + 32'd4) movf = 1'b0;
        end
    end

    always @(negedge clk) begin : compare
        logic        exp_tx;
        logic        exp_busy;
        logic [31:0] exp_rd;
        if (chk_on) begin
            exp_tx = 1'b1;
            if (mwave.size() > 0) exp_tx = mwave[0];
            exp_busy = (mwave.size() > 0) || (mq.size() > 0);
            exp_rd = 32'h0;
            if (DataAdr == BASE + 32'd4)
                exp_rd = {29'h0, movf, (mq.size() == DEPTH), exp_busy};
            check("tx", {31'h0, tx}, {31'h0, exp_tx});
            check("busy", {31'h0, busy}, {31'h0, exp_busy});
            check("Hit", {31'h0, Hit}, {31'h0, ((DataAdr >> 3) == (BASE >> 3))});
            check("RdData", RdData, exp_rd);
        end
    end

    task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d);
        MemWrite  = w;
        DataAdr   = a;
        WriteData = d;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        DataAdr  = 32'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0);
    endtask

    task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
        MemWrite = 1'b0;
        DataAdr  = a;
        #1;
        check(name, RdData, exp);
    endtask

    initial begin
        logic [9:0]  exp55;
        logic [31:0] a;
        int          cnt;
        int          r;
        int          zeros;

        exp55 = {1'b1, 8'h55, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_on = 1'b1;

        // Reset state and quiet line.
        idle(50);
        check("idle_tx", {31'h0, tx}, 32'h1);
        check("idle_busy", {31'h0, busy}, 32'h0);
        peek("idle_status", BASE + 32'd4, 32'h0);
        check("idle_hit", {31'h0, Hit}, 32'h1);

        // Single frame 0x55, sampled mid-bit.
        cyc(1'b1, BASE, 32'h0000_0055);
        for (int k = 0; k < 10; k++) begin
            idle(k == 0 ? 2 : 4);
            check($sformatf("f55_bit%0d", k), {31'h0, tx}, {31'h0, exp55[k]});
        end
        idle(2);
        check("f55_busy_last", {31'h0, busy}, 32'h1);
        idle(1);
        check("f55_busy_fall", {31'h0, busy}, 32'h0);

        // Three back-to-back frames.
        cyc(1'b1, BASE, 32'h0000_00A5);
        cyc(1'b1, BASE, 32'h0000_003C);
        cyc(1'b1, BASE, 32'h0000_00FF);
        cnt = 0;
        while (busy && cnt < 400) begin
            idle(1);
            cnt++;
            if (cnt == 38) check("b2b_stop1", {31'h0, tx}, 32'h1);
            if (cnt == 39) check("b2b_start2", {31'h0, tx}, 32'h0);
        end
        check("b2b_cycles", cnt, 119);

        // Overflow: six stores into a depth-4 FIFO.
        for (int i = 0; i < 6; i++) cyc(1'b1, BASE, 32'h10 + i);
        peek("ovf_status", BASE + 32'd4, 32'h7);
        cnt = 0;
        while (busy && cnt < 400) begin
            idle(1);
            cnt++;
        end
        check("ovf_cycles", cnt, 196);
        peek("ovf_sticky", BASE + 32'd4, 32'h4);
        cyc(1'b1, BASE + 32'd4, 32'hFFFF_FFFF);
        peek("ovf_clear", BASE + 32'd4, 32'h0);

        // Reset mid-DATA with two bytes queued.
        cyc(1'b1, BASE, 32'h0000_000F);
        cyc(1'b1, BASE, 32'h0000_0011);
        cyc(1'b1, BASE, 32'h0000_0022);
        idle(8);
        reset = 1'b1;
        cyc(1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        check("rst_tx", {31'h0, tx}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        zeros = 0;
        for (int i = 0; i < 60; i++) begin
            idle(1);
            if (tx !== 1'b1) zeros++;
        end
        check("rst_no_frames", zeros, 0);

`ifdef UART_PARITY_EN
        cyc(1'b1, BASE, 32'h0000_0007);
        cnt = 0;
        while (busy && cnt < 200) begin
            idle(1);
            cnt++;
            if (cnt == 38) check("par_bit", {31'h0, tx}, 32'h1);
        end
        check("par_cycles", cnt, 45);
`endif

        // Randomised traffic against the model.
        for (int it = 0; it < 1500; it++) begin
            r = $urandom_range(0, 99);
            if (it == 700) begin
                reset = 1'b1;
                cyc(1'b0, 32'h0, 32'h0);
                reset = 1'b0;
            end else if (r < 12) begin
                cyc(1'b1, BASE, $urandom);
            end else if (r < 15) begin
                cyc(1'b1, BASE + 32'd4, $urandom);
            end else if (r < 25) begin
                a = 32'($urandom_range(1, 7));
                if (a == 32'd4) a = 32'd5;
                cyc(1'b1, BASE + a, $urandom);
            end else if (r < 30) begin
                a = $urandom;
                if ((a >> 3) == (BASE >> 3)) a = a ^ 32'h8000_0000;
                cyc(1'b1, a, $urandom);
            end else if (r < 45) begin
                cyc(1'b0, BASE + 32'($urandom_range(0, 7)), $urandom);
            end else begin
                idle(1);
            end
        end
        cnt = 0;
        while (busy && cnt < 2000) begin
            idle(1);
            cnt++;
        end
        check("drain_done", {31'h0, busy}, 32'h0);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
